// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) with halt handshake, retired count and illegal-op trap.
// Moore outputs from registered state plus IR decode; 3-5 cycles per instruction; Halt only honoured at instruction end.
module mc_ctrl (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [5:0]  OP,
  input  logic [5:0]  func,
  input  logic        Z,
  input  logic        Overflow,
  input  logic        Halt,
  output logic        PCWr,
  output logic        PCWrCond,
  output logic        IorD,
  output logic        IRWr,
  output logic        MemWr,
  output logic        RegWr,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic        ExtOp,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUctr,
  output logic [2:0]  State,
  output logic        InstDone,
  output logic [31:0] InstCnt,
  output logic        Err
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101,
    S_TRAP = 3'b110
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instcnt;
  logic        r_ovf;
  logic        r_err;
  logic        w_done;

  // The branch compare result is consumed by the datapath, never by the FSM.
  logic w_unused;
  assign w_unused = Z;

  logic w_rtype, w_addi, w_ori, w_lw, w_sw, w_beq, w_j;
  logic w_r_legal, w_legal, w_alu_ovf;
  logic [2:0] w_r_aluctr;

  assign w_rtype = (OP == 6'b000000);
  assign w_addi  = (OP == 6'b001000);
  assign w_ori   = (OP == 6'b001101);
  assign w_lw    = (OP == 6'b100011);
  assign w_sw    = (OP == 6'b101011);
  assign w_beq   = (OP == 6'b000100);
  assign w_j     = (OP == 6'b000010);

  always_comb begin
    w_r_aluctr = 3'b000;
    w_r_legal  = 1'b1;
    case (func)
      6'b100000: w_r_aluctr = 3'b000;
      6'b100010: w_r_aluctr = 3'b001;
      6'b100100: w_r_aluctr = 3'b010;
      6'b100101: w_r_aluctr = 3'b011;
      6'b101010: w_r_aluctr = 3'b100;
      default:   w_r_legal  = 1'b0;
    endcase
  end

  assign w_legal   = (w_rtype & w_r_legal) | w_addi | w_ori | w_lw | w_sw | w_beq | w_j;
  assign w_alu_ovf = (w_rtype & ((func == 6'b100000) | (func == 6'b100010))) | w_addi;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_instcnt <= 32'd0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_done) r_instcnt <= r_instcnt + 32'd1;
      if (r_state == S_EX) r_ovf <= w_alu_ovf & Overflow;
      if (w_next == S_TRAP) r_err <= 1'b1;
    end
  end

  always_comb begin
    PCWr     = 1'b0;
    PCWrCond = 1'b0;
    IorD     = 1'b0;
    IRWr     = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ExtOp    = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUctr   = 3'b000;
    w_done   = 1'b0;
    w_next   = r_state;
    case (r_state)
      S_IF: begin
        IRWr    = 1'b1;
        ALUSrcB = 2'b01;
        PCWr    = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        w_next  = w_legal ? S_EX : S_TRAP;
      end
      S_EX: begin
        if (w_rtype) begin
          ALUSrcA = 1'b1;
          ALUctr  = w_r_aluctr;
        end else if (w_addi | w_lw | w_sw) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ExtOp   = 1'b1;
        end else if (w_ori) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUctr  = 3'b011;
        end else if (w_beq) begin
          ALUSrcA  = 1'b1;
          ALUctr   = 3'b001;
          PCWrCond = 1'b1;
          PCSrc    = 2'b01;
        end else if (w_j) begin
          PCWr  = 1'b1;
          PCSrc = 2'b10;
        end
        if (w_beq | w_j)     w_done = 1'b1;
        else if (w_lw | w_sw) w_next = S_MEM;
        else                  w_next = S_WB;
      end
      S_MEM: begin
        IorD  = 1'b1;
        MemWr = w_sw;
        if (w_sw) w_done = 1'b1;
        else      w_next = S_WB;
      end
      S_WB: begin
        // A signed overflow in EX suppresses the ALU writeback.
        RegWr    = w_lw | ~r_ovf;
        RegDst   = w_rtype;
        MemtoReg = w_lw;
        w_done   = 1'b1;
      end
      S_HALT:  w_next = Halt ? S_HALT : S_IF;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IF;
    endcase
    if (w_done) w_next = Halt ? S_HALT : S_IF;
    if (Clr) begin
      PCWr     = 1'b0;
      PCWrCond = 1'b0;
      IRWr     = 1'b0;
      MemWr    = 1'b0;
      RegWr    = 1'b0;
    end
  end

  assign State    = r_state;
  assign InstDone = w_done;
  assign InstCnt  = r_instcnt;
  assign Err      = r_err;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-cycle expectations from an instruction-level model, checked by a queue-driven monitor.
module tb_mc_ctrl;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic [5:0]  OP = 6'd0;
  logic [5:0]  func = 6'd0;
  logic        Z = 1'b0;
  logic        Overflow = 1'b0;
  logic        Halt = 1'b0;
  logic        PCWr, PCWrCond, IorD, IRWr, MemWr, RegWr, RegDst, MemtoReg, ALUSrcA, ExtOp;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUctr, State;
  logic        InstDone, Err;
  logic [31:0] InstCnt;

  mc_ctrl dut (
    .Clk(Clk), .Clr(Clr), .OP(OP), .func(func), .Z(Z), .Overflow(Overflow), .Halt(Halt),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .IRWr(IRWr), .MemWr(MemWr),
    .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ExtOp(ExtOp),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUctr(ALUctr), .State(State),
    .InstDone(InstDone), .InstCnt(InstCnt), .Err(Err)
  );

  always #5 Clk = ~Clk;

  localparam int ST_IF = 0, ST_ID = 1, ST_EX = 2, ST_MEM = 3, ST_WB = 4, ST_HALT = 5, ST_TRAP = 6;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010;

  typedef struct packed {
    logic [31:0] idx;
    logic [5:0]  op;
    logic [21:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] m_cnt = 32'd0;
  bit          m_ovfr = 1'b0;
  bit          m_err = 1'b0;

  function automatic bit rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
    if (op == OP_R) return fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR || fn == F_SLT;
    return op == OP_ADDI || op == OP_ORI || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J;
  endfunction

  function automatic int n_cycles(logic [5:0] op);
    if (op == OP_BEQ || op == OP_J) return 3;
    if (op == OP_LW) return 5;
    return 4;
  endfunction

  function automatic int state_of(logic [5:0] op, int k);
    case (k)
      0: return ST_IF;
      1: return ST_ID;
      2: return ST_EX;
      3: return (op == OP_LW || op == OP_SW) ? ST_MEM : ST_WB;
      default: return ST_WB;
    endcase
  endfunction

  // Control word the instruction set table demands for one cycle.
  function automatic logic [21:0] exp_ctl(int st, logic [5:0] op, logic [5:0] fn, bit ovfr, bit last, bit err, bit clr);
    bit pcwr = 0, pcwrc = 0, iord = 0, irwr = 0, memwr = 0, regwr = 0, regdst = 0, m2r = 0, asa = 0, ext = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b000;
    bit aluinst = (op == OP_R) || op == OP_ADDI || op == OP_ORI;
    case (st)
      ST_IF: begin irwr = 1; asb = 2'b01; pcwr = 1; end
      ST_ID: begin asb = 2'b11; ext = 1; end
      ST_EX: begin
        if (op == OP_R) begin
          asa = 1;
          alu = (fn == F_SUB) ? 3'd1 : (fn == F_AND) ? 3'd2 : (fn == F_OR) ? 3'd3 : (fn == F_SLT) ? 3'd4 : 3'd0;
        end else if (op == OP_ADDI || op == OP_LW || op == OP_SW) begin
          asa = 1; asb = 2'b10; ext = 1;
        end else if (op == OP_ORI) begin
          asa = 1; asb = 2'b10; alu = 3'd3;
        end else if (op == OP_BEQ) begin
          asa = 1; alu = 3'd1; pcwrc = 1; pcs = 2'b01;
        end else if (op == OP_J) begin
          pcwr = 1; pcs = 2'b10;
        end
      end
      ST_MEM: begin iord = 1; memwr = (op == OP_SW); end
      ST_WB: begin
        if (op == OP_LW) begin m2r = 1; regwr = 1; end
        else if (aluinst) begin regdst = (op == OP_R); regwr = !ovfr; end
      end
      default: ;
    endcase
    if (clr) begin pcwr = 0; pcwrc = 0; irwr = 0; memwr = 0; regwr = 0; end
    return {3'(st), pcwr, pcwrc, iord, irwr, memwr, regwr, regdst, m2r, asa, ext, asb, pcs, alu, last, err};
  endfunction

  task automatic push(int st, bit last, bit clr);
    exp_t e;
    e.idx = cyc;
    e.op  = OP;
    e.ctl = exp_ctl(st, OP, func, m_ovfr, last, m_err, clr);
    e.cnt = m_cnt;
    q.push_back(e);
    cyc++;
  endtask

  task automatic do_reset(int n);
    repeat (n) begin
      @(posedge Clk); #1;
      Clr = 1'b1;
      m_cnt = 0; m_ovfr = 0; m_err = 0;
      push(ST_IF, 0, 1);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit ovf, input int halt_from,
                           input bit halt_final, input int halt_cycles, input int abort_at, input int trap_cycles);
    bit legal = is_legal(op, fn);
    int n = legal ? n_cycles(op) : 2;
    bit last;
    for (int k = 0; k < n; k++) begin
      @(posedge Clk); #1;
      if (k == abort_at) begin
        Clr = 1'b1;
        m_cnt = 0; m_ovfr = 0; m_err = 0;
        push(ST_IF, 0, 1);
        return;
      end
      Clr = 1'b0;
      OP = op; func = fn; Z = rb();
      Overflow = (k == 2) ? ovf : rb();
      last = legal && (k == n - 1);
      Halt = last ? halt_final : ((halt_from >= 0 && k >= halt_from) ? 1'b1 : rb());
      push(state_of(op, k), last, 0);
      if (k == 2) m_ovfr = ((op == OP_R && (fn == F_ADD || fn == F_SUB)) || op == OP_ADDI) ? ovf : 1'b0;
    end
    if (!legal) begin
      m_err = 1;
      repeat (trap_cycles) begin
        @(posedge Clk); #1;
        Halt = rb(); Z = rb(); Overflow = rb();
        push(ST_TRAP, 0, 0);
      end
      return;
    end
    m_cnt = m_cnt + 1;
    if (halt_final) begin
      repeat (halt_cycles) begin
        @(posedge Clk); #1;
        Halt = 1'b1; OP = 6'($urandom); func = 6'($urandom);
        push(ST_HALT, 0, 0);
      end
      @(posedge Clk); #1;
      Halt = 1'b0;
      push(ST_HALT, 0, 0);
    end
  endtask

  function automatic logic [5:0] legal_op(int sel);
    case (sel)
      0, 1, 2, 3, 4: return OP_R;
      5: return OP_ADDI;
      6: return OP_ORI;
      7: return OP_LW;
      8: return OP_SW;
      9: return OP_BEQ;
      default: return OP_J;
    endcase
  endfunction

  function automatic logic [5:0] legal_fn(int sel);
    case (sel)
      0: return F_ADD;
      1: return F_SUB;
      2: return F_AND;
      3: return F_OR;
      4: return F_SLT;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [21:0] got;
    forever begin
      @(negedge Clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        got = {State, PCWr, PCWrCond, IorD, IRWr, MemWr, RegWr, RegDst, MemtoReg, ALUSrcA, ExtOp,
               ALUSrcB, PCSrc, ALUctr, InstDone, Err};
        n_tests++;
        if (got !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl cyc=%0d op=%b got=%b exp=%b", e.idx, e.op, got, e.ctl);
        end
        n_tests++;
        if (InstCnt !== e.cnt) begin
          n_fail++;
          $display("FAIL instcnt cyc=%0d got=%0d exp=%0d", e.idx, InstCnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, r, n;
    logic [5:0] op, fn;
    do_reset(3);
    run_instr(OP_ADDI, 6'd5, 1'b0, -1, 1'b0, 0, -1, 0);
    run_instr(OP_R, F_ADD, 1'b1, -1, 1'b0, 0, -1, 0);
    run_instr(OP_LW, 6'd0, 1'b1, -1, 1'b0, 0, -1, 0);
    run_instr(OP_SW, 6'd0, 1'b0, -1, 1'b0, 0, -1, 0);
    run_instr(OP_BEQ, 6'd0, 1'b0, -1, 1'b0, 0, -1, 0);
    run_instr(OP_BEQ, 6'd0, 1'b1, -1, 1'b0, 0, -1, 0);
    run_instr(OP_J, 6'd0, 1'b0, -1, 1'b0, 0, -1, 0);
    run_instr(OP_ADDI, 6'd1, 1'b1, 1, 1'b1, 3, -1, 0);
    run_instr(OP_R, F_SUB, 1'b0, -1, 1'b0, 0, -1, 0);
    run_instr(OP_SW, 6'd0, 1'b0, -1, 1'b0, 0, 3, 0);
    run_instr(OP_ORI, 6'd0, 1'b1, -1, 1'b0, 0, -1, 0);
    run_instr(6'b111111, 6'd0, 1'b0, -1, 1'b0, 0, -1, 20);
    do_reset(2);
    run_instr(OP_R, 6'b000111, 1'b0, -1, 1'b0, 0, -1, 3);
    do_reset(1);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        op = 6'($urandom); fn = 6'($urandom);
        if (is_legal(op, fn)) op = 6'b111111;
        run_instr(op, fn, rb(), -1, 1'b0, 0, -1, $urandom_range(3, 8));
        do_reset($urandom_range(1, 2));
      end else begin
        sel = $urandom_range(0, 10);
        op = legal_op(sel); fn = legal_fn(sel);
        n = n_cycles(op);
        if (r < 11) run_instr(op, fn, rb(), -1, 1'b0, 0, $urandom_range(0, n - 1), 0);
        else        run_instr(op, fn, rb(), -1, ($urandom_range(0, 9) == 0), $urandom_range(0, 3), -1, 0);
      end
    end
    repeat (2) @(negedge Clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
